pq_replace_ctrl: RTL and testbench
==================================

Name: pq_replace_ctrl

Overview:
- Front-end issue controller sitting directly upstream of the register-tree priority queue (min on top).
- Accepts DEQ / REPLACE requests over a valid/ready handshake and drives the tree's replace strobe and new item only in legal issue slots.
- Returns the popped top item through a one-entry valid/ready output register.
- Enforces the tree's two-phase sift timing so no item is lost.

Parameters:
- DATA_WIDTH, 32, width of items, equal to the tree's DATA_WIDTH.
- REPLACE_GAP, 4, minimum cycles between consecutive tree replace strobes; legal values are even and ≥4.
- SENTINEL, all-ones of DATA_WIDTH, value inserted on DEQ, which marks an empty slot.

Ports:
- clk  input  1  clock
- rst_n  input  1  synchronous active-low reset; the tree's rst is driven from ~rst_n in the same cycle
- in_valid  input  1  request present
- in_ready  output  1  request accepted when in_valid && in_ready
- in_op  input  1  0 = DEQ (pop, insert SENTINEL), 1 = REPLACE (pop, insert in_data)
- in_data  input  DATA_WIDTH  item to insert for REPLACE
- out_valid  output  1  popped item available
- out_ready  input  1  consumer takes item when out_valid && out_ready
- out_data  output  DATA_WIDTH  popped item (tree top at accept)
- out_empty  output  1  popped item equalled SENTINEL, meaning the queue was empty
- tree_replace  output  1  to tree replace
- tree_new_item  output  DATA_WIDTH  to tree new_item
- tree_top_item  input  DATA_WIDTH  from tree top_item

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-low (rst_n).
- Reset values: phase=0, state=READY, gap_cnt=0, out_valid=0, out_data=0, out_empty=0, in_ready=0 during reset.
- Phase tracking:
  - phase toggles every cycle after reset.
  - It mirrors the tree's level indicator, which is valid only because both leave reset on the same edge.
  - Issue is legal only when phase==0, the tree's even/root phase.
- States:
  - READY: waiting for a request.
  - COOL: gap_cnt counting down.
- in_ready = (state==READY) && (phase==0) && (!out_valid || out_ready). This is combinational and does not depend on in_valid.
- On accept (in_valid && in_ready), in the same cycle:
  - tree_replace=1, combinational.
  - tree_new_item = in_op ? in_data : SENTINEL. tree_new_item=SENTINEL whenever tree_replace=0.
  - Next edge: out_data<=tree_top_item, out_empty<=(tree_top_item==SENTINEL), out_valid<=1.
  - gap_cnt<=REPLACE_GAP-1, state<=COOL.
- Latency: popped item appears one cycle after accept.
- Maximum rate: one op per REPLACE_GAP cycles.
- COOL: gap_cnt decrements each cycle. At gap_cnt==1 the next state is READY, so the next accept can occur exactly REPLACE_GAP cycles after the previous one; that cycle has phase==0.
- Output register:
  - Cleared (out_valid<=0) when out_valid && out_ready and there is no accept in the same cycle.
  - A simultaneous pop and accept reloads it, keeping out_valid=1.
- Backpressure: when out_valid=1 and out_ready=0, in_ready=0 and no replace is issued. When out_ready rises, the issue waits for the next phase==0 cycle.
- DEQ on an empty queue: still issues a replace (SENTINEL over SENTINEL). out_data=SENTINEL and out_empty=1; this is not an error.
- REPLACE with in_data==SENTINEL: behaves identically to DEQ.
- Reset mid-operation: all state is discarded, including a pending out_valid. The first legal issue is on the first cycle after reset deasserts (phase==0).
- in_data and in_op are sampled only on accept; values in other cycles are don't-care.

Optional Feature:
- Macro: PQ_CTRL_STATS_EN.
- When defined, three extra output ports are added:
  - stat_ops (32): accepted operations.
  - stat_empty (16): accepts where tree_top_item==SENTINEL.
  - stat_stall (32): cycles with in_valid=1 and in_ready=0.
- Stats counters are all reset to 0 by rst_n and saturate at all-ones.
- When the macro is not defined, these ports and counters do not exist, and the remaining behaviour is identical.

Test Plan:
- Reset, tree loaded so its top reads 10; in_valid=1, op=REPLACE, data=5 held continuously, out_ready=1:
  - Accepts occur at cycles 0, 4, 8 after reset.
  - tree_replace is high only on those cycles.
  - out_data=10 at cycle 1; subsequent out_data equals tree_top_item at each accept.
- Request arrives at an odd phase (cycle 1): in_ready=0 at cycle 1. Accept at cycle 2 requires the previous op ≥4 cycles earlier; otherwise the accept occurs at the first even cycle after cooldown.
- out_ready=0 after the first pop:
  - out_valid stays 1 and out_data is held.
  - in_ready=0 throughout; no tree_replace.
  - Raising out_ready at cycle 9 gives the next accept at cycle 10 (even).
- Drain with 16 DEQs from a full 15-node tree:
  - First 15 pops are non-decreasing values with out_empty=0.
  - Sixteenth pop is out_data=all-ones with out_empty=1.
- Assert rst_n=0 in the cycle after an accept while out_valid=1:
  - Next cycle out_valid=0, state=READY, phase=0.
  - First post-reset request is accepted immediately.
- PQ_CTRL_STATS_EN defined, 3 accepts plus 5 stalled cycles, one accept on an empty queue: stat_ops=3, stat_stall=5, stat_empty=1.

Source files
------------

// File: rtl/pq_replace_ctrl.sv
// Issue controller in front of the register-tree min priority queue: paces replace strobes
// to the tree's even phase and cooldown, and returns the popped top item. Option: PQ_CTRL_STATS_EN.
`timescale 1ns/1ps
module pq_replace_ctrl #(
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    REPLACE_GAP = 4,
    parameter logic [DATA_WIDTH-1:0] SENTINEL    = '1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_op,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_empty,
    output logic                  tree_replace,
    output logic [DATA_WIDTH-1:0] tree_new_item,
    input  logic [DATA_WIDTH-1:0] tree_top_item
`ifdef PQ_CTRL_STATS_EN
    ,
    output logic [31:0]           stat_ops,
    output logic [15:0]           stat_empty,
    output logic [31:0]           stat_stall
`endif
);

    localparam int CNT_W = (REPLACE_GAP > 2) ? $clog2(REPLACE_GAP) : 1;

    typedef enum logic {READY, COOL} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] gap_cnt, gap_nxt;
    logic             phase;
    logic             accept;

    // phase mirrors the tree's level indicator; both leave reset on the same edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= READY;
            gap_cnt <= '0;
            phase   <= 1'b0;
        end else begin
            // NOTE: state is updated with <= so every register sees pre-edge values.
            state   <= state_nxt;
            gap_cnt <= gap_nxt;
            phase   <= ~phase;
        end
    end

    always_comb begin
        // NOTE: defaults first so no path leaves a signal unassigned (no latch).
        state_nxt = state;
        gap_nxt   = gap_cnt;
        case (state)
            READY: begin
                if (accept) begin
                    state_nxt = COOL;
                    gap_nxt   = CNT_W'(REPLACE_GAP - 1);
                end
            end
            COOL: begin
                gap_nxt = gap_cnt - CNT_W'(1);
                if (gap_cnt == CNT_W'(1)) state_nxt = READY;
            end
            default: state_nxt = READY;
        endcase
    end

    // Issue only on the even phase, after cooldown, with room in the output register.
    always_comb begin
        in_ready      = rst_n && (state == READY) && !phase && (!out_valid || out_ready);
        accept        = in_valid && in_ready;
        tree_replace  = accept;
        tree_new_item = (accept && in_op) ? in_data : SENTINEL;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_empty <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_data  <= tree_top_item;
            out_empty <= (tree_top_item == SENTINEL);
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef PQ_CTRL_STATS_EN
    // Saturating event counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_ops   <= '0;
            stat_empty <= '0;
            stat_stall <= '0;
        end else begin
            if (accept && stat_ops != '1)
                stat_ops <= stat_ops + 32'd1;
            if (accept && tree_top_item == SENTINEL && stat_empty != '1)
                stat_empty <= stat_empty + 16'd1;
            if (in_valid && !in_ready && stat_stall != '1)
                stat_stall <= stat_stall + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pq_replace_ctrl.sv
// Self-checking bench for pq_replace_ctrl: a bag-of-items tree stand-in plus a cycle-count
// model of the issue rules, compared every cycle, with directed literal checks.
`timescale 1ns/1ps
module tb_pq_replace_ctrl;

    localparam int              DW   = 32;
    localparam int              GAP  = 4;
    localparam logic [DW-1:0]   SENT = '1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_op = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          out_ready = 1'b0;
    logic [DW-1:0] tree_top_item = SENT;
    logic          in_ready, out_valid, out_empty, tree_replace;
    logic [DW-1:0] out_data, tree_new_item;
`ifdef PQ_CTRL_STATS_EN
    logic [31:0]   stat_ops, stat_stall;
    logic [15:0]   stat_empty;
`endif

    pq_replace_ctrl #(.DATA_WIDTH(DW), .REPLACE_GAP(GAP), .SENTINEL(SENT)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_op         (in_op),
        .in_data       (in_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .out_empty     (out_empty),
        .tree_replace  (tree_replace),
        .tree_new_item (tree_new_item),
        .tree_top_item (tree_top_item)
`ifdef PQ_CTRL_STATS_EN
        ,
        .stat_ops      (stat_ops),
        .stat_empty    (stat_empty),
        .stat_stall    (stat_stall)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: cycles since reset, cycle of last accept, output register contents, tree bag.
    bit            live = 1'b0;
    int            cyc = 0;
    int            last_acc = -GAP;
    logic          m_ov = 1'b0;
    logic [DW-1:0] m_od = '0;
    logic          m_oe = 1'b0;
    int            m_ops = 0, m_empty = 0, m_stall = 0;
    int            acc_log[$];
    logic [DW-1:0] bag[$];

    function automatic bit exp_ready();
        return live && rst_n && (cyc % 2 == 0) && (cyc - last_acc >= GAP) && (!m_ov || out_ready);
    endfunction

    function automatic logic [DW-1:0] bag_min();
        logic [DW-1:0] m;
        m = SENT;
        foreach (bag[i]) if (bag[i] < m) m = bag[i];
        return m;
    endfunction

    always @(posedge clk) begin
        bit            acc;
        logic [DW-1:0] item;
        int            idx;
        acc  = 1'b0;
        item = SENT;
        if (!rst_n) begin
            live = 1'b1; cyc = 0; last_acc = -GAP;
            m_ov = 1'b0; m_od = '0; m_oe = 1'b0;
            m_ops = 0; m_empty = 0; m_stall = 0;
            acc_log.delete();
        end else if (live) begin
            acc = in_valid && exp_ready();
            if (in_valid && !exp_ready()) m_stall++;
            if (acc) begin
                item = in_op ? in_data : SENT;
                m_ov = 1'b1;
                m_od = tree_top_item;
                m_oe = (tree_top_item == SENT);
                last_acc = cyc;
                acc_log.push_back(cyc);
                m_ops++;
                if (tree_top_item == SENT) m_empty++;
            end else if (m_ov && out_ready) begin
                m_ov = 1'b0;
            end
            cyc++;
        end
        #1;
        if (acc) begin
            idx = 0;
            foreach (bag[i]) if (bag[i] < bag[idx]) idx = i;
            if (bag.size() > 0) bag.delete(idx);
            bag.push_back(item);
        end
        tree_top_item = bag_min();
    end

    // Compare process: every cycle once the model has seen a reset edge.
    always @(negedge clk) begin
        bit r, a;
        if (live) begin
            r = exp_ready();
            a = in_valid && r;
            check("in_ready", in_ready, r);
            check("tree_replace", tree_replace, a);
            check("tree_new_item", tree_new_item, a ? (in_op ? in_data : SENT) : SENT);
            check("out_valid", out_valid, m_ov);
            check("out_data", out_data, m_od);
            check("out_empty", out_empty, m_oe);
`ifdef PQ_CTRL_STATS_EN
            check("stat_ops", stat_ops, m_ops);
            check("stat_empty", stat_empty, m_empty);
            check("stat_stall", stat_stall, m_stall);
`endif
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    // Leaves the bench at cycle 0 (first cycle with rst_n high).
    task automatic do_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        steps(2);
        rst_n = 1'b1;
    endtask

    task automatic load_bag(input logic [DW-1:0] v [15]);
        bag.delete();
        for (int i = 0; i < 15; i++) bag.push_back(v[i]);
        tree_top_item = bag_min();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected finish before %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] small_a [15];
        logic [DW-1:0] empty_a [15];
        logic [DW-1:0] full_a  [15];
        logic [DW-1:0] prev;
        logic [9:0]    vpat;

        small_a = '{10, 20, 30, SENT, SENT, SENT, SENT, SENT, SENT, SENT, SENT, SENT, SENT, SENT, SENT};
        empty_a = '{SENT, SENT, SENT, SENT, SENT, SENT, SENT, SENT, SENT, SENT, SENT, SENT, SENT, SENT, SENT};
        full_a  = '{42, 3, 17, 99, 3, 8, 65, 21, 1000, 5, 77, 12, 30, 2, 50};

        // Back-to-back REPLACE 5 over a tree topped by 10: accepts every GAP cycles.
        do_reset();
        load_bag(small_a);
        in_valid = 1'b1; in_op = 1'b1; in_data = 5; out_ready = 1'b1;
        at_neg();
        check("t1_accept_c0", tree_replace, 1);
        step();
        at_neg();
        check("t1_valid_c1", out_valid, 1);
        check("t1_pop_c1", out_data, 10);
        steps(4);
        at_neg();
        check("t1_pop_c5", out_data, 5);
        steps(5);
        check("t1_acc_count", acc_log.size(), 3);
        check("t1_acc0", acc_log[0], 0);
        check("t1_acc1", acc_log[1], 4);
        check("t1_acc2", acc_log[2], 8);

        // Request arriving on an odd phase waits one cycle; then cooldown applies.
        do_reset();
        load_bag(empty_a);
        out_ready = 1'b1;
        step();
        in_valid = 1'b1; in_op = 1'b0;
        at_neg();
        check("t2_odd_ready", in_ready, 0);
        step();
        at_neg();
        check("t2_accept_c2", tree_replace, 1);
        step();
        at_neg();
        check("t2_empty_pop", out_empty, 1);
        check("t2_empty_data", out_data, SENT);
        step();
        at_neg();
        check("t2_cool_ready", in_ready, 0);
        steps(2);
        in_op = 1'b1; in_data = SENT;
        at_neg();
        check("t2_accept_c6", tree_replace, 1);
        check("t2_sent_item", tree_new_item, SENT);
        step();
        in_valid = 1'b0;
        steps(3);

        // Backpressure holds the output and blocks issue until out_ready rises.
        do_reset();
        load_bag(small_a);
        in_valid = 1'b1; in_op = 1'b1; in_data = 5;
        steps(5);
        at_neg();
        check("t3_held_valid", out_valid, 1);
        check("t3_held_data", out_data, 10);
        check("t3_blocked", in_ready, 0);
        steps(4);
        out_ready = 1'b1;
        at_neg();
        check("t3_c9_ready", in_ready, 0);
        step();
        at_neg();
        check("t3_accept_c10", tree_replace, 1);
        step();
        at_neg();
        check("t3_pop_c11", out_data, 5);
        in_valid = 1'b0;
        steps(4);

        // Drain a full tree with 16 DEQs.
        do_reset();
        load_bag(full_a);
        in_valid = 1'b1; in_op = 1'b0; out_ready = 1'b1;
        prev = '0;
        for (int k = 0; k < 16; k++) begin
            step();
            at_neg();
            if (k == 0) check("t4_first_pop", out_data, 2);
            if (k < 15) begin
                check("t4_nondecreasing", out_data >= prev, 1);
                check("t4_not_empty", out_empty, 0);
                prev = out_data;
            end else begin
                check("t4_last_data", out_data, SENT);
                check("t4_last_empty", out_empty, 1);
            end
            steps(3);
        end
        in_valid = 1'b0;
        steps(2);

        // Reset in the cycle after an accept discards the pending output.
        do_reset();
        load_bag(small_a);
        in_valid = 1'b1; in_op = 1'b1; in_data = 5;
        step();
        rst_n = 1'b0;
        at_neg();
        check("t5_pending_valid", out_valid, 1);
        check("t5_ready_in_reset", in_ready, 0);
        step();
        rst_n = 1'b1;
        at_neg();
        check("t5_cleared_valid", out_valid, 0);
        check("t5_ready_after", in_ready, 1);
        check("t5_accept_after", tree_replace, 1);
        step();
        at_neg();
        check("t5_pop_after", out_data, 5);
        in_valid = 1'b0;
        out_ready = 1'b1;
        steps(4);

        // Three accepts, five stalled cycles, one pop from an empty queue.
        do_reset();
        load_bag(empty_a);
        out_ready = 1'b1; in_op = 1'b1;
        vpat = 10'b01_1101_1111;
        for (int i = 0; i < 10; i++) begin
            in_valid = vpat[i];
            in_data  = (i == 0) ? 7 : ((i == 4) ? 8 : 3);
            step();
        end
        in_valid = 1'b0;
        check("t6_model_ops", m_ops, 3);
        check("t6_model_stall", m_stall, 5);
        check("t6_model_empty", m_empty, 1);
`ifdef PQ_CTRL_STATS_EN
        at_neg();
        check("t6_stat_ops", stat_ops, 3);
        check("t6_stat_stall", stat_stall, 5);
        check("t6_stat_empty", stat_empty, 1);
`endif
        steps(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
